// File: rtl/ones_count_accumulator.sv
// Frame accumulator for the per-word ones count: sums FRAME_LEN beats, tracks the
// largest beat and saturation, and holds the result on a valid/ready output.
//
// state | meaning
// ACCUM | accepting beats, in_ready=1
// DONE  | frame result presented, waiting for out_ready
module ones_count_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] total,
  output logic [1:0]       frame_max,
  output logic             sat
);

  localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [SUM_W-1:0] acc, acc_nxt;
  logic [1:0]       mx, mx_nxt;
  logic [7:0]       beat;
  logic             sat_r, sat_nxt;
  logic [SUM_W:0]   sum_wide;
  logic             accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // One extra bit of headroom: the carry out is exactly the saturation condition.
  always_comb begin
    sum_wide = {1'b0, acc} + {{(SUM_W-1){1'b0}}, count};
    sat_nxt  = sat_r | sum_wide[SUM_W];
    acc_nxt  = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
    mx_nxt   = (count > mx) ? count : mx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      mx        <= '0;
      beat      <= '0;
      sat_r     <= 1'b0;
      total     <= '0;
      frame_max <= '0;
      sat       <= 1'b0;
    end else if (accept) begin
      if (last) begin
        total     <= acc_nxt;
        frame_max <= mx_nxt;
        sat       <= sat_nxt;
        acc       <= '0;
        mx        <= '0;
        beat      <= '0;
        sat_r     <= 1'b0;
      end else begin
        acc   <= acc_nxt;
        mx    <= mx_nxt;
        sat_r <= sat_nxt;
        beat  <= beat + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Scoreboard bench: drives two instances (SUM_W=5 and SUM_W=4) in lockstep and
// compares every presented frame result against a bench-side model.
module tb_ones_count_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] count;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready, out_valid, sat;
  logic [4:0] total;
  logic [1:0] frame_max;
  logic       in_ready_s, out_valid_s, sat_s;
  logic [3:0] total_s;
  logic [1:0] frame_max_s;

  ones_count_accumulator #(.FRAME_LEN(8), .SUM_W(5)) u_dut (
    .clk(clk), .rst(rst), .count(count), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .total(total),
    .frame_max(frame_max), .sat(sat)
  );

  ones_count_accumulator #(.FRAME_LEN(8), .SUM_W(4)) u_sat (
    .clk(clk), .rst(rst), .count(count), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .total(total_s),
    .frame_max(frame_max_s), .sat(sat_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t5;
    int t4;
    int mx;
    int s5;
    int s4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  int m_beat, m5, m4, mmx, ms5, ms4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_beat = 0; m5 = 0; m4 = 0; mmx = 0; ms5 = 0; ms4 = 0;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    sb.delete();
  endtask

  // Offers one beat, waits (bounded) for in_ready, and updates the model on acceptance.
  task automatic send_beat(input int c, output int w);
    exp_t e;
    count    = 2'(c);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m_beat++;
    m5 += c; if (m5 > 31) begin m5 = 31; ms5 = 1; end
    m4 += c; if (m4 > 15) begin m4 = 15; ms4 = 1; end
    if (c > mmx) mmx = c;
    if (m_beat == 8) begin
      e.t5 = m5; e.t4 = m4; e.mx = mmx; e.s5 = ms5; e.s4 = ms4;
      sb.push_back(e);
      model_clear();
    end
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("in_ready_vs_out_valid", {31'b0, in_ready}, {31'b0, ~out_valid});
      check("valid_lockstep", {31'b0, out_valid_s}, {31'b0, out_valid});
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("total", {27'b0, total}, sb[0].t5);
          check("frame_max", {30'b0, frame_max}, sb[0].mx);
          check("sat", {31'b0, sat}, sb[0].s5);
          check("total_w4", {28'b0, total_s}, sb[0].t4);
          check("frame_max_w4", {30'b0, frame_max_s}, sb[0].mx);
          check("sat_w4", {31'b0, sat_s}, sb[0].s4);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int mixed[8] = '{0, 1, 2, 1, 0, 1, 2, 1};
    int bp[8]    = '{2, 3, 1, 0, 3, 2, 1, 2};

    rst = 1'b1; count = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    do_reset(2);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_total", {27'b0, total}, 0);
    check("rst_frame_max", {30'b0, frame_max}, 0);
    check("rst_sat", {31'b0, sat}, 0);
    mon_en = 1'b1;

    // full-count frame, back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(3, w);
      check("full_no_wait", w, 0);
      if (i < 7) check("full_no_early_valid", {31'b0, out_valid}, 0);
    end
    check("full_latency", {31'b0, out_valid}, 1);

    // mixed values with bubbles; first beat waits only the DONE cycle
    for (int i = 0; i < 8; i++) begin
      send_beat(mixed[i], w);
      if (i == 0) check("next_frame_wait", w, 1);
      if (i < 7) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // backpressure with in_valid held high during DONE
    while (out_valid) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(bp[i], w);
    check("bp_out_valid", {31'b0, out_valid}, 1);
    count = 2'd3; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {31'b0, out_valid}, 1);
      check("bp_in_ready_low", {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;

    // saturation on the narrow instance, then a clean frame
    for (int i = 0; i < 8; i++) begin
      send_beat(3, w);
      if (i == 0) check("bp_release_wait", w, 1);
    end
    for (int i = 0; i < 8; i++) send_beat(1, w);

    // reset mid-frame
    while (out_valid) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) send_beat(2, w);
    do_reset(1);
    check("midrst_total", {27'b0, total}, 0);
    check("midrst_in_ready", {31'b0, in_ready}, 1);
    for (int i = 0; i < 8; i++) send_beat(1, w);

    // reset while a result is pending under backpressure
    while (out_valid) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(2, w);
    check("donerst_pending", {31'b0, out_valid}, 1);
    do_reset(1);
    check("donerst_out_valid", {31'b0, out_valid}, 0);
    check("donerst_total", {27'b0, total}, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(i % 3, w);

    w = 0;
    while (sb.size() != 0 && w < 20) begin @(posedge clk); #1; w++; end
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ones_count_accumulator.md
# ones_count_accumulator

Frame accumulator directly downstream of `number_of_1s_count`. It takes the 2-bit per-word ones count, one beat per valid cycle, and sums FRAME_LEN beats into a frame total. It also tracks the largest single-beat count and a saturation flag, then presents the result on a valid/ready output until the consumer takes it. This turns the combinational popcount into a framed, flow-controlled statistic for the next stage of the datapath.

## Interface
- FRAME_LEN, 8, beats per frame; legal range 2..255
- SUM_W, 5, width of `total`; must be at least 2. Values below ceil(log2(3*FRAME_LEN+1)) make saturation reachable.
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`
- count  input  2  ones count of the current word, 0..3, from `number_of_1s_count`
- in_valid  input  1  `count` is valid this cycle
- in_ready  output  1  block accepts a beat this cycle
- out_valid  output  1  frame result is valid
- out_ready  input  1  consumer takes the result this cycle
- total  output  SUM_W  sum of the frame's counts, saturated at 2^SUM_W-1
- frame_max  output  2  largest single `count` in the frame
- sat  output  1  the frame sum exceeded 2^SUM_W-1

## Operation
- Two-state FSM: ACCUM and DONE. Reset state is ACCUM.
- Internal registers:
  - `acc` [SUM_W-1:0]
  - `mx` [1:0]
  - `beat` [7:0]
  - `sat_r`
- **ACCUM:**
  - `in_ready`=1, `out_valid`=0.
  - A beat is accepted when `in_valid`=1.
  - On each accepted beat:
    - `acc` becomes `acc`+`count`, computed at SUM_W+1 bits. If the result exceeds 2^SUM_W-1, `acc` is clamped to 2^SUM_W-1 and `sat_r` is set. `sat_r` stays set for the rest of the frame.
    - `mx` becomes max(`mx`, `count`).
    - `beat` increments.
  - Cycles with `in_valid`=0 are bubbles and change nothing.
  - The accepted beat with `beat`==FRAME_LEN-1 closes the frame:
    - `total`, `frame_max` and `sat` are registered from the updated values.
    - The FSM moves to DONE.
    - `acc`, `mx`, `beat` and `sat_r` clear to 0.
- **DONE:**
  - `in_ready`=0 and `out_valid`=1. `count` and `in_valid` are ignored.
  - `total`, `frame_max` and `sat` hold stable while `out_valid`=1 and `out_ready`=0.
  - When `out_valid` and `out_ready` are both 1, the FSM returns to ACCUM on the next edge.
  - No same-cycle bypass: the new frame's first beat can be accepted at the earliest one cycle after the output handshake.
- `out_valid` depends only on state. Neither ready depends combinationally on the other side's valid.
- `total`, `frame_max` and `sat` keep the last frame's values after the handshake until the next frame closes. Consumers must qualify them with `out_valid`.
- **Reset:**
  - Applies in any state, including mid-frame and during DONE with `out_ready` low.
  - Next cycle: state ACCUM, all internal registers 0, any partial or pending frame discarded.
  - `rst` has priority over every handshake in the same cycle.

## Timing
- Output values in the cycle after `rst` is sampled high:
  - `in_ready`=1
  - `out_valid`=0
  - `total`=0
  - `frame_max`=0
  - `sat`=0
- Latency: last beat accepted at edge t gives `out_valid`=1 from t+1.
- Throughput: with `out_ready` tied high, one frame per FRAME_LEN+1 cycles. The extra cycle is the DONE state.
- Beat accepted at edge t gives `acc` updated at t+1. Internal values are not visible until the frame closes.
- Wrap-around: `beat` never exceeds FRAME_LEN-1. It returns to 0 on the closing beat.
- Saturation is per frame. `sat_r` never carries over into the next frame.
- Frame size boundary: the smallest legal frame is FRAME_LEN=2.

## Test plan
- **Reset values:** hold `rst` high for 2 cycles, then release → `in_ready`=1, `out_valid`=0, `total`=0, `frame_max`=0, `sat`=0.
- **Full-count frame:** defaults; 8 consecutive beats with `count`=3 and `out_ready`=1 → `out_valid` high exactly one cycle after the 8th beat with `total`=24, `frame_max`=3, `sat`=0. Next frame is accepted immediately after.
- **Bubbles and mixed values:** counts 0,1,2,1,0,1,2,1 interleaved with `in_valid`=0 gaps of 1–3 cycles → `total`=8, `frame_max`=2. Bubbles change nothing.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises → outputs stable and `in_ready`=0 throughout. After the handshake, the next frame's first beat is accepted no earlier than the following cycle.
- **Saturation:** SUM_W=4, FRAME_LEN=8, all beats `count`=3 → `total`=15, `sat`=1. The next frame of all `count`=1 gives `total`=8, `sat`=0.
- **Reset mid-frame:** assert `rst` after 5 beats of `count`=2, then send 8 beats of `count`=1 → `total`=8, `frame_max`=1. No leftover contribution from the aborted frame.
